// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU: opcodes, sequencer micro-steps and the
// control-word bit layout that the PC, RAM, ALU and IR blocks decode from.
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;

   typedef enum logic [3:0] {
      CW_OUT_IN  = 4'd0,
      CW_FLAG_IN = 4'd1,
      CW_ALU_SUB = 4'd2,
      CW_ALU_OUT = 4'd3,
      CW_B_IN    = 4'd4,
      CW_A_OUT   = 4'd5,
      CW_A_IN    = 4'd6,
      CW_IR_OUT  = 4'd7,
      CW_IR_IN   = 4'd8,
      CW_RAM_IN  = 4'd9,
      CW_RAM_OUT = 4'd10,
      CW_MAR_IN  = 4'd11,
      CW_PC_IN   = 4'd12,
      CW_PC_INC  = 4'd13,
      CW_PC_OUT  = 4'd14
   } cw_bit_e;

   localparam int CW_W = 15;
   typedef logic [CW_W-1:0] ctrl_word_t;

   function automatic ctrl_word_t cw(input cw_bit_e b);
      ctrl_word_t w;
      w    = '0;
      w[b] = 1'b1;
      return w;
   endfunction

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_JZ) || (op == OP_OUT) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/ir_sequencer_decode.sv
// Combinational micro-step decode: (step, opcode, flags) -> control word,
// plus whether this step ends the instruction and whether it requests halt.
module ir_sequencer_decode
   import cpu_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic [2:0]  step,
   input  logic [3:0]  opcode,
   input  logic        cf,
   input  logic        zf,
   output ctrl_word_t  ctrl,
   output logic        last_step,
   output logic        halt_req
);

   logic is_nop;

   // NOP-like opcodes end at T1, so the opcode is consulted there only for length.
   assign is_nop = (opcode == OP_NOP) || (!HALT_ON_ILLEGAL && !op_is_legal(opcode));

   always_comb begin
      ctrl      = '0;
      last_step = 1'b0;
      halt_req  = 1'b0;
      case (step)
         T0: ctrl = cw(CW_PC_OUT) | cw(CW_MAR_IN);
         T1: begin
            ctrl      = cw(CW_RAM_OUT) | cw(CW_IR_IN) | cw(CW_PC_INC);
            last_step = is_nop;
         end
         T2, T3, T4: begin
            case (opcode)
               OP_LDA, OP_STA: begin
                  if (step == T2) begin
                     ctrl = cw(CW_IR_OUT) | cw(CW_MAR_IN);
                  end else begin
                     if (step == T3)
                        ctrl = (opcode == OP_LDA) ? (cw(CW_RAM_OUT) | cw(CW_A_IN))
                                                  : (cw(CW_A_OUT) | cw(CW_RAM_IN));
                     last_step = 1'b1;
                  end
               end
               OP_ADD, OP_SUB: begin
                  if (step == T2) begin
                     ctrl = cw(CW_IR_OUT) | cw(CW_MAR_IN);
                  end else if (step == T3) begin
                     ctrl = cw(CW_RAM_OUT) | cw(CW_B_IN);
                  end else begin
                     ctrl = cw(CW_ALU_OUT) | cw(CW_A_IN) | cw(CW_FLAG_IN);
                     if (opcode == OP_SUB)
                        ctrl = ctrl | cw(CW_ALU_SUB);
                     last_step = 1'b1;
                  end
               end
               OP_LDI: begin
                  if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_A_IN);
                  last_step = 1'b1;
               end
               OP_JMP: begin
                  if (step == T2) ctrl = cw(CW_IR_OUT) | cw(CW_PC_IN);
                  last_step = 1'b1;
               end
               OP_JC: begin
                  if (step == T2 && cf) ctrl = cw(CW_IR_OUT) | cw(CW_PC_IN);
                  last_step = 1'b1;
               end
               OP_JZ: begin
                  if (step == T2 && zf) ctrl = cw(CW_IR_OUT) | cw(CW_PC_IN);
                  last_step = 1'b1;
               end
               OP_OUT: begin
                  if (step == T2) ctrl = cw(CW_A_OUT) | cw(CW_OUT_IN);
                  last_step = 1'b1;
               end
               OP_HLT: begin
                  halt_req  = (step == T2);
                  last_step = 1'b1;
               end
               OP_NOP: last_step = 1'b1;
               default: begin
                  halt_req  = HALT_ON_ILLEGAL && (step == T2);
                  last_step = 1'b1;
               end
            endcase
         end
         default: last_step = 1'b1;
      endcase
   end

endmodule

// File: rtl/ir_sequencer.sv
// CPU sequencer: T0..T4 step counter with early termination, sticky halt,
// and gating of the decoded control word onto the individual bus strobes.
module ir_sequencer
   import cpu_pkg::*;
#(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ir_ins,
   input  logic       cf,
   input  logic       zf,
   output logic       pc_out,
   output logic       pc_inc,
   output logic       pc_in,
   output logic       mar_in,
   output logic       ram_out,
   output logic       ram_in,
   output logic       ir_in,
   output logic       ir_out,
   output logic       a_in,
   output logic       a_out,
   output logic       b_in,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       flag_in,
   output logic       out_in,
   output logic       halted,
   output logic [2:0] t_step
);

   logic [2:0] t_step_reg;
   logic [2:0] t_step_next;
   logic       halted_reg;
   logic       halted_next;
   ctrl_word_t ctrl;
   ctrl_word_t ctrl_gated;
   logic       last_step;
   logic       halt_req;

   ir_sequencer_decode #(
      .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
   ) u_decode (
      .step      (t_step_reg),
      .opcode    (ir_ins),
      .cf        (cf),
      .zf        (zf),
      .ctrl      (ctrl),
      .last_step (last_step),
      .halt_req  (halt_req)
   );

   always_comb begin
      t_step_next = t_step_reg + 3'd1;
      halted_next = halted_reg;
      if (halted_reg) begin
         t_step_next = T0;
      end else begin
         if (last_step || t_step_reg >= T4)
            t_step_next = T0;
         if (halt_req)
            halted_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_step_reg <= T0;
         halted_reg <= 1'b0;
      end else begin
         t_step_reg <= t_step_next;
         halted_reg <= halted_next;
      end
   end

   // T0 decodes to fetch strobes, so reset itself must mask them as well as halt.
   assign ctrl_gated = (rst_n && !halted_reg) ? ctrl : '0;

   assign pc_out  = ctrl_gated[CW_PC_OUT];
   assign pc_inc  = ctrl_gated[CW_PC_INC];
   assign pc_in   = ctrl_gated[CW_PC_IN];
   assign mar_in  = ctrl_gated[CW_MAR_IN];
   assign ram_out = ctrl_gated[CW_RAM_OUT];
   assign ram_in  = ctrl_gated[CW_RAM_IN];
   assign ir_in   = ctrl_gated[CW_IR_IN];
   assign ir_out  = ctrl_gated[CW_IR_OUT];
   assign a_in    = ctrl_gated[CW_A_IN];
   assign a_out   = ctrl_gated[CW_A_OUT];
   assign b_in    = ctrl_gated[CW_B_IN];
   assign alu_out = ctrl_gated[CW_ALU_OUT];
   assign alu_sub = ctrl_gated[CW_ALU_SUB];
   assign flag_in = ctrl_gated[CW_FLAG_IN];
   assign out_in  = ctrl_gated[CW_OUT_IN];
   assign halted  = halted_reg;
   assign t_step  = t_step_reg;

endmodule

// File: tb/tb_ir_sequencer.sv
// Directed bench for ir_sequencer: two instances (illegal = NOP / illegal = halt)
// run in lockstep; strobes are packed as {pc_out..out_in} and compared per step.
module tb_ir_sequencer;

   localparam logic [14:0] PC_OUT  = 15'h4000;
   localparam logic [14:0] PC_INC  = 15'h2000;
   localparam logic [14:0] PC_IN   = 15'h1000;
   localparam logic [14:0] MAR_IN  = 15'h0800;
   localparam logic [14:0] RAM_OUT = 15'h0400;
   localparam logic [14:0] RAM_IN  = 15'h0200;
   localparam logic [14:0] IR_IN   = 15'h0100;
   localparam logic [14:0] IR_OUT  = 15'h0080;
   localparam logic [14:0] A_IN    = 15'h0040;
   localparam logic [14:0] A_OUT   = 15'h0020;
   localparam logic [14:0] B_IN    = 15'h0010;
   localparam logic [14:0] ALU_OUT = 15'h0008;
   localparam logic [14:0] ALU_SUB = 15'h0004;
   localparam logic [14:0] FLAG_IN = 15'h0002;
   localparam logic [14:0] OUT_IN  = 15'h0001;
   localparam logic [14:0] F0      = PC_OUT | MAR_IN;
   localparam logic [14:0] F1      = RAM_OUT | IR_IN | PC_INC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] ir_ins = 4'h0;
   logic       cf = 1'b0;
   logic       zf = 1'b0;
   wire [14:0] obs;
   wire [14:0] obs_hi;
   wire        halted;
   wire        halted_hi;
   wire [2:0]  t_step;
   wire [2:0]  t_step_hi;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   ir_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .ir_ins(ir_ins), .cf(cf), .zf(zf),
      .pc_out(obs[14]), .pc_inc(obs[13]), .pc_in(obs[12]), .mar_in(obs[11]),
      .ram_out(obs[10]), .ram_in(obs[9]), .ir_in(obs[8]), .ir_out(obs[7]),
      .a_in(obs[6]), .a_out(obs[5]), .b_in(obs[4]), .alu_out(obs[3]),
      .alu_sub(obs[2]), .flag_in(obs[1]), .out_in(obs[0]),
      .halted(halted), .t_step(t_step)
   );

   ir_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut_hi (
      .clk(clk), .rst_n(rst_n), .ir_ins(ir_ins), .cf(cf), .zf(zf),
      .pc_out(obs_hi[14]), .pc_inc(obs_hi[13]), .pc_in(obs_hi[12]), .mar_in(obs_hi[11]),
      .ram_out(obs_hi[10]), .ram_in(obs_hi[9]), .ir_in(obs_hi[8]), .ir_out(obs_hi[7]),
      .a_in(obs_hi[6]), .a_out(obs_hi[5]), .b_in(obs_hi[4]), .alu_out(obs_hi[3]),
      .alu_sub(obs_hi[2]), .flag_in(obs_hi[1]), .out_in(obs_hi[0]),
      .halted(halted_hi), .t_step(t_step_hi)
   );

   // number of bus drivers (pc_out, ram_out, ir_out, a_out, alu_out) asserted
   function automatic int drivers(input logic [14:0] s);
      return int'(s[14]) + int'(s[10]) + int'(s[7]) + int'(s[5]) + int'(s[3]);
   endfunction

   task automatic test_reset();
      logic [14:0] e [5];
      rst_n = 1'b0; ir_ins = 4'h0; cf = 1'b0; zf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (obs !== 15'h0 || obs_hi !== 15'h0 || t_step !== 3'd0 || halted !== 1'b0 || halted_hi !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: strobes=%04h/%04h t_step=%0d halted=%b/%b, required 0000 t_step=0 halted=0",
                  obs, obs_hi, t_step, halted, halted_hi);
      end
      rst_n = 1'b1;
      e = '{F0, F1, 15'h0, 15'h0, 15'h0};
      for (int k = 0; k < 2; k++) begin
         ir_ins = (k == 0) ? 4'h9 : 4'h0;
         @(negedge clk);
         tests++;
         if (t_step !== 3'(k) || obs !== e[k] || t_step_hi !== 3'(k) || obs_hi !== e[k]) begin
            fails++;
            $display("FAIL fetch_nop T%0d: t_step=%0d strobes=%04h (hi %0d/%04h), required t_step=%0d strobes=%04h",
                     k, t_step, obs, t_step_hi, obs_hi, k, e[k]);
         end
         @(posedge clk); #1;
      end
      tests++;
      if (t_step !== 3'd0 || obs !== F0 || t_step_hi !== 3'd0) begin
         fails++;
         $display("FAIL fetch_nop end: t_step=%0d/%0d strobes=%04h, required t_step=0 strobes=%04h",
                  t_step, t_step_hi, obs, F0);
      end
   endtask

   task automatic test_loads();
      logic [3:0]  ops  [6] = '{4'h1, 4'h4, 4'h5, 4'h6, 4'hE, 4'h0};
      int          lens [6] = '{4, 4, 3, 3, 3, 2};
      logic [14:0] e2   [6] = '{IR_OUT | MAR_IN, IR_OUT | MAR_IN, IR_OUT | A_IN,
                                IR_OUT | PC_IN, A_OUT | OUT_IN, 15'h0};
      logic [14:0] e3   [6] = '{RAM_OUT | A_IN, A_OUT | RAM_IN, 15'h0, 15'h0, 15'h0, 15'h0};
      logic [14:0] e [5];
      for (int i = 0; i < 6; i++) begin
         e = '{F0, F1, e2[i], e3[i], 15'h0};
         for (int k = 0; k < lens[i]; k++) begin
            ir_ins = (k == 0) ? (ops[i] ^ 4'h9) : ops[i];
            @(negedge clk);
            tests++;
            if (t_step !== 3'(k) || obs !== e[k] || t_step_hi !== 3'(k) || obs_hi !== e[k] || drivers(obs) > 1) begin
               fails++;
               $display("FAIL op_%h T%0d: t_step=%0d strobes=%04h (hi %0d/%04h), required t_step=%0d strobes=%04h",
                        ops[i], k, t_step, obs, t_step_hi, obs_hi, k, e[k]);
            end
            @(posedge clk); #1;
         end
         tests++;
         if (t_step !== 3'd0 || obs !== F0 || halted !== 1'b0 || t_step_hi !== 3'd0) begin
            fails++;
            $display("FAIL op_%h end: t_step=%0d strobes=%04h halted=%b, required t_step=0 strobes=%04h halted=0",
                     ops[i], t_step, obs, halted, F0);
         end
      end
   endtask

   task automatic test_alu();
      logic [14:0] e [5];
      logic [3:0]  op;
      for (int i = 0; i < 2; i++) begin
         op = (i == 1) ? 4'h3 : 4'h2;
         e  = '{F0, F1, IR_OUT | MAR_IN, RAM_OUT | B_IN,
                ALU_OUT | A_IN | FLAG_IN | ((i == 1) ? ALU_SUB : 15'h0)};
         for (int k = 0; k < 5; k++) begin
            ir_ins = (k == 0) ? 4'h0 : op;
            @(negedge clk);
            tests++;
            if (t_step !== 3'(k) || obs !== e[k] || obs_hi !== e[k] || drivers(obs) > 1) begin
               fails++;
               $display("FAIL alu_%h T%0d: t_step=%0d strobes=%04h (hi %04h), required t_step=%0d strobes=%04h",
                        op, k, t_step, obs, obs_hi, k, e[k]);
            end
            @(posedge clk); #1;
         end
         tests++;
         if (t_step !== 3'd0 || obs !== F0) begin
            fails++;
            $display("FAIL alu_%h end: t_step=%0d strobes=%04h, required t_step=0 strobes=%04h", op, t_step, obs, F0);
         end
      end
   endtask

   task automatic test_jumps();
      logic [3:0]  ops [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
      logic        cfs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic        zfs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [14:0] e2  [4] = '{15'h0, IR_OUT | PC_IN, 15'h0, IR_OUT | PC_IN};
      logic [14:0] e [5];
      for (int i = 0; i < 4; i++) begin
         e  = '{F0, F1, e2[i], 15'h0, 15'h0};
         cf = cfs[i];
         zf = zfs[i];
         for (int k = 0; k < 3; k++) begin
            ir_ins = (k == 0) ? 4'h3 : ops[i];
            @(negedge clk);
            tests++;
            if (t_step !== 3'(k) || obs !== e[k] || obs_hi !== e[k] || drivers(obs) > 1) begin
               fails++;
               $display("FAIL jump_%h cf=%b zf=%b T%0d: t_step=%0d strobes=%04h, required t_step=%0d strobes=%04h",
                        ops[i], cf, zf, k, t_step, obs, k, e[k]);
            end
            @(posedge clk); #1;
         end
         tests++;
         if (t_step !== 3'd0 || obs !== F0) begin
            fails++;
            $display("FAIL jump_%h end: t_step=%0d strobes=%04h, required t_step=0 strobes=%04h",
                     ops[i], t_step, obs, F0);
         end
      end
      cf = 1'b0;
      zf = 1'b0;
   endtask

   task automatic test_halt();
      logic [14:0] e [3];
      e = '{F0, F1, 15'h0};
      for (int k = 0; k < 3; k++) begin
         ir_ins = (k == 0) ? 4'h0 : 4'hF;
         @(negedge clk);
         tests++;
         if (t_step !== 3'(k) || obs !== e[k] || halted !== 1'b0 || obs_hi !== e[k]) begin
            fails++;
            $display("FAIL hlt T%0d: t_step=%0d strobes=%04h halted=%b, required t_step=%0d strobes=%04h halted=0",
                     k, t_step, obs, halted, k, e[k]);
         end
         @(posedge clk); #1;
      end
      tests++;
      if (halted !== 1'b1 || halted_hi !== 1'b1 || t_step !== 3'd0 || obs !== 15'h0 || obs_hi !== 15'h0) begin
         fails++;
         $display("FAIL hlt_set: halted=%b/%b t_step=%0d strobes=%04h/%04h, required halted=1 t_step=0 strobes=0000",
                  halted, halted_hi, t_step, obs, obs_hi);
      end
      ir_ins = 4'h1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         tests++;
         if (halted !== 1'b1 || t_step !== 3'd0 || obs !== 15'h0 || obs_hi !== 15'h0 || t_step_hi !== 3'd0) begin
            fails++;
            $display("FAIL hlt_hold cycle %0d: halted=%b t_step=%0d strobes=%04h/%04h, required halted=1 t_step=0 strobes=0000",
                     c, halted, t_step, obs, obs_hi);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      tests++;
      if (halted !== 1'b0 || halted_hi !== 1'b0 || t_step !== 3'd0 || obs !== 15'h0) begin
         fails++;
         $display("FAIL hlt_reset: halted=%b/%b t_step=%0d strobes=%04h, required halted=0 t_step=0 strobes=0000",
                  halted, halted_hi, t_step, obs);
      end
      rst_n  = 1'b1;
      ir_ins = 4'h0;
      e = '{F0, F1, 15'h0};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         tests++;
         if (t_step !== 3'(k) || obs !== e[k] || obs_hi !== e[k]) begin
            fails++;
            $display("FAIL hlt_resume T%0d: t_step=%0d strobes=%04h, required t_step=%0d strobes=%04h",
                     k, t_step, obs, k, e[k]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] e [4];
      e = '{F0, F1, IR_OUT | MAR_IN, RAM_OUT | A_IN};
      for (int k = 0; k < 4; k++) begin
         ir_ins = (k == 0) ? 4'h8 : 4'h1;
         @(negedge clk);
         tests++;
         if (t_step !== 3'(k) || obs !== e[k] || obs_hi !== e[k]) begin
            fails++;
            $display("FAIL lda_pre_reset T%0d: t_step=%0d strobes=%04h, required t_step=%0d strobes=%04h",
                     k, t_step, obs, k, e[k]);
         end
         if (k < 3) begin
            @(posedge clk); #1;
         end
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (obs !== 15'h0 || obs_hi !== 15'h0 || t_step !== 3'd0 || t_step_hi !== 3'd0) begin
         fails++;
         $display("FAIL mid_reset: strobes=%04h/%04h t_step=%0d/%0d, required strobes=0000 t_step=0",
                  obs, obs_hi, t_step, t_step_hi);
      end
      @(posedge clk); #1;
      rst_n  = 1'b1;
      ir_ins = 4'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         tests++;
         if (t_step !== 3'(k) || obs !== ((k == 0) ? F0 : F1)) begin
            fails++;
            $display("FAIL mid_reset_refetch T%0d: t_step=%0d strobes=%04h, required t_step=%0d strobes=%04h",
                     k, t_step, obs, k, (k == 0) ? F0 : F1);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      ir_ins = 4'h5;
      @(negedge clk);
      tests++;
      if (t_step !== 3'd0 || obs !== F0 || t_step_hi !== 3'd0 || obs_hi !== F0) begin
         fails++;
         $display("FAIL illegal T0: t_step=%0d/%0d strobes=%04h/%04h, required t_step=0 strobes=%04h",
                  t_step, t_step_hi, obs, obs_hi, F0);
      end
      @(posedge clk); #1;
      ir_ins = 4'hA;
      @(negedge clk);
      tests++;
      if (t_step !== 3'd1 || obs !== F1 || t_step_hi !== 3'd1 || obs_hi !== F1) begin
         fails++;
         $display("FAIL illegal T1: t_step=%0d/%0d strobes=%04h/%04h, required t_step=1 strobes=%04h",
                  t_step, t_step_hi, obs, obs_hi, F1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (t_step !== 3'd0 || obs !== F0 || t_step_hi !== 3'd2 || obs_hi !== 15'h0 || halted_hi !== 1'b0) begin
         fails++;
         $display("FAIL illegal step3: nop t_step=%0d strobes=%04h, halt t_step=%0d strobes=%04h halted=%b; required nop 0/%04h, halt 2/0000/0",
                  t_step, obs, t_step_hi, obs_hi, halted_hi, F0);
      end
      @(posedge clk); #1;
      tests++;
      if (t_step !== 3'd1 || halted !== 1'b0 || halted_hi !== 1'b1 || t_step_hi !== 3'd0 || obs_hi !== 15'h0) begin
         fails++;
         $display("FAIL illegal end: nop t_step=%0d halted=%b, halt t_step=%0d halted=%b strobes=%04h; required nop 1/0, halt 0/1/0000",
                  t_step, halted, t_step_hi, halted_hi, obs_hi);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_alu();
      test_jumps();
      test_halt();
      test_reset_mid();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ir_sequencer.md
Name: ir_sequencer

Overview:
- Controller/sequencer for the 8-bit CPU, sitting on the other side of the instruction register.
- Consumes the 4-bit opcode `ir_ins` from IR.
- Drives IR's `ir_in`/`ir_out` strobes and every other bus control strobe, one micro-step per clock.
- Runs a fetch/execute step counter with variable-length instructions and a sticky halt.

Parameters:
- HALT_ON_ILLEGAL, 0, 1 = unlisted opcode halts; 0 = unlisted opcode executes as NOP.

Ports:
- clk      in   1  system clock, rising-edge
- rst_n    in   1  asynchronous reset, active-low
- ir_ins   in   4  opcode from IR (upper nibble of the latched instruction)
- cf       in   1  ALU carry flag (registered elsewhere)
- zf       in   1  ALU zero flag (registered elsewhere)
- pc_out   out  1  PC drives bus
- pc_inc   out  1  PC increment
- pc_in    out  1  PC loads from bus
- mar_in   out  1  MAR loads from bus
- ram_out  out  1  RAM drives bus
- ram_in   out  1  RAM writes from bus
- ir_in    out  1  IR loads from bus
- ir_out   out  1  IR drives address/immediate nibble onto bus
- a_in     out  1  accumulator loads from bus
- a_out    out  1  accumulator drives bus
- b_in     out  1  B register loads from bus
- alu_out  out  1  ALU drives bus
- alu_sub  out  1  ALU subtract select
- flag_in  out  1  flag register captures ALU flags
- out_in   out  1  output register loads from bus
- halted   out  1  sticky halt indicator
- t_step   out  3  current micro-step, binary 0..4 (debug)

Behaviour:
- Reset (async, rst_n=0):
  - t_step=0, halted=0.
  - All strobes are combinational from state, so all are 0 while reset is asserted.
  - Reset mid-instruction abandons the instruction; the first cycle after release is T0.
- Step counter T0..T4 advances on each rising clk.
- At the last active step of an instruction, the next step is T0 (early termination).
- T4 always returns to T0.
- Strobes are a combinational decode of (t_step, ir_ins, cf, zf, halted).
- At most one bus driver is asserted per step.
- Fetch, identical for all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
  - ir_ins is treated as valid only from T2 onward; its value during T0/T1 is ignored.
- Opcodes, execute steps (op: steps):
  - NOP 0000: none; T1 is the last step.
  - LDA 0001: T2 ir_out, mar_in; T3 ram_out, a_in.
  - ADD 0010: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, flag_in.
  - SUB 0011: as ADD; alu_sub is also asserted in T4.
  - STA 0100: T2 ir_out, mar_in; T3 a_out, ram_in.
  - LDI 0101: T2 ir_out, a_in.
  - JMP 0110: T2 ir_out, pc_in.
  - JC 0111: T2 ir_out, pc_in only if cf=1. T2 is the last step either way.
  - JZ 1000: T2 ir_out, pc_in only if zf=1. T2 is the last step either way.
  - OUT 1110: T2 a_out, out_in.
  - HLT 1111: T2 no strobes; halted is set on the T2->next edge.
  - Others: NOP, or HLT if HALT_ON_ILLEGAL=1.
- cf/zf are sampled combinationally during T2 only.
- Halt behaviour:
  - Once halted=1, t_step holds at 0 and all strobes are forced to 0, including the T0 fetch strobes.
  - Only rst_n clears halted.
- Step counter never takes the values 5..7. If it does, the next state is T0 and strobes are 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - step localparams T0..T4;
  - a control-word bit-index enum, so the PC, RAM, ALU and IR blocks share the encoding.
- One sub-module is natural: ir_sequencer_decode, purely combinational, mapping (step, opcode, cf, zf) to a control word and a last_step flag.
- Top level holds the step counter, the halt register and strobe gating.

Test Plan:
- Reset/fetch: release rst_n, ir_ins=0000.
  - T0: pc_out=mar_in=1.
  - T1: ram_out=ir_in=pc_inc=1.
  - Next cycle: t_step=0 (NOP, 2 cycles).
- ADD: ir_ins=0010 held from T1 -> T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+flag_in, alu_sub=0; then t_step=0. Repeat with 0011 -> alu_sub=1 in T4 only.
- Conditional jumps:
  - JC with cf=0 -> T2 has no strobes, then T0.
  - JC with cf=1 -> T2 ir_out+pc_in.
  - Repeat JZ with zf=0/1.
- HLT: ir_ins=1111 -> halted=1 after T2, t_step=0.
  - No strobe for 10 further cycles, even with ir_ins changed to 0001.
  - Pulse rst_n -> fetch resumes.
- Reset mid-instruction: assert rst_n low asynchronously during T3 of LDA -> all strobes 0 immediately; t_step=0 after release; fetch restarts.
- Illegal opcode 1010:
  - HALT_ON_ILLEGAL=0 -> 2-cycle NOP.
  - HALT_ON_ILLEGAL=1 -> halted=1 after T2.
- Every step of every test: at most one of pc_out/ram_out/ir_out/a_out/alu_out is asserted.
